fib_stack_resp: RTL

- LIFO stack responder on the datapath side of the Fibonacci controller's stack interface.
- Accepts push/pop strobes from the controller and stores operands (n-1, n-2) written by the datapath.
- Presents top-of-stack to the datapath and returns is_empty to the controller's next-state logic.
- Adds full detection and sticky overflow/underflow error flags.

---
 rtl/fib_stack_resp_pkg.sv | 12 +
 rtl/fib_stack_resp_if.sv | 35 +++
 rtl/fib_stack_resp_ptr.sv | 74 +++++++
 rtl/fib_stack_resp.sv | 44 ++++
 4 files changed

// File: rtl/fib_stack_resp_pkg.sv
// fib_stack_resp_pkg: shared defaults, command-pair encodings and occupancy states for the stack responder.
package fib_stack_resp_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_POP  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_REPL = 2'b11
    } cmd_e;
    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_e;
endpackage

// File: rtl/fib_stack_resp_if.sv
// fib_stack_resp_if: controller/datapath-side stack bus; hwm exists only with FIB_STACK_HWM_EN.
interface fib_stack_resp_if
    import fib_stack_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             is_empty;
    logic             is_full;
    logic [PTR_W-1:0] count;
    logic             ovf;
    logic             unf;
`ifdef FIB_STACK_HWM_EN
    logic [PTR_W-1:0] hwm;
`endif
    modport master (
        output push, pop, din,
        input  dout, is_empty, is_full, count, ovf, unf
`ifdef FIB_STACK_HWM_EN
        , input hwm
`endif
    );
    modport slave (
        input  push, pop, din,
        output dout, is_empty, is_full, count, ovf, unf
`ifdef FIB_STACK_HWM_EN
        , output hwm
`endif
    );
endinterface

// File: rtl/fib_stack_resp_ptr.sv
// fib_stack_ptr: saturating occupancy counter, full/empty and sticky error flags, write addressing.
// With FIB_STACK_HWM_EN it also keeps the high-water mark.
module fib_stack_ptr
    import fib_stack_resp_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] count,
    output logic             is_empty,
    output logic             is_full,
    output logic             ovf,
    output logic             unf,
    output logic             we,
    output logic [PTR_W-2:0] waddr
`ifdef FIB_STACK_HWM_EN
    , output logic [PTR_W-1:0] hwm
`endif
);
    cmd_e             cmd;
    state_e           state;
    logic [PTR_W-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    always_comb begin
        cmd       = cmd_e'({push, pop});
        state     = (count == '0) ? ST_EMPTY : (count == PTR_W'(DEPTH)) ? ST_FULL : ST_PARTIAL;
        count_nxt = count;
        ovf_nxt   = ovf;
        unf_nxt   = unf;
        case (cmd)
            CMD_PUSH: begin
                count_nxt = (state == ST_FULL) ? count : count + 1'b1;
                ovf_nxt   = ovf | (state == ST_FULL);
            end
            CMD_POP: begin
                count_nxt = (state == ST_EMPTY) ? count : count - 1'b1;
                unf_nxt   = unf | (state == ST_EMPTY);
            end
            // replace-top on a non-empty stack; on an empty one it degrades to a plain push
            CMD_REPL: count_nxt = (state == ST_EMPTY) ? count + 1'b1 : count;
            default: ;
        endcase
    end

    assign is_empty = state == ST_EMPTY;
    assign is_full  = state == ST_FULL;
    assign we       = push & (pop | (state != ST_FULL));
    assign waddr    = (pop && state != ST_EMPTY) ? count[PTR_W-2:0] - 1'b1 : count[PTR_W-2:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

`ifdef FIB_STACK_HWM_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) hwm <= '0;
        else      hwm <= (count > hwm) ? count : hwm;
    end
`endif
endmodule

// File: rtl/fib_stack_resp.sv
// fib_stack_resp: LIFO stack responder for the Fibonacci controller; storage and top-of-stack read mux.
// Optional high-water mark output enabled by FIB_STACK_HWM_EN.
module fib_stack_resp
    import fib_stack_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input logic           clk,
    input logic           clr,
    fib_stack_resp_if.slave bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             we;
    logic [PTR_W-2:0] waddr;
    logic [PTR_W-2:0] top_idx;

    fib_stack_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr (
        .clk      (clk),
        .clr      (clr),
        .push     (bus.push),
        .pop      (bus.pop),
        .count    (bus.count),
        .is_empty (bus.is_empty),
        .is_full  (bus.is_full),
        .ovf      (bus.ovf),
        .unf      (bus.unf),
        .we       (we),
        .waddr    (waddr)
`ifdef FIB_STACK_HWM_EN
        , .hwm    (bus.hwm)
`endif
    );

    // storage needs no reset: dout is forced to zero while empty
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= bus.din;
    end

    // at count==DEPTH the truncated index wraps to 0, so -1 lands on DEPTH-1
    assign top_idx  = bus.count[PTR_W-2:0] - 1'b1;
    assign bus.dout = bus.is_empty ? '0 : mem[top_idx];
endmodule
